// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin share of one ALU between two requesters.
// Optional divide-by-zero trap enabled by defining ALU_DIVZERO_TRAP_EN.
module alu_issue_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_v,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_s
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                        MUL_CYCLES : DIV_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic          rr;
  logic          port;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [CW-1:0] cnt;
  logic [31:0]   result_q;
  logic [3:0]    flags_q;

  logic          any_req;
  logic          grant;
  logic          accept;
  logic [2:0]    sel_op;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;
  logic [CW-1:0] lat_m1;
  logic          trap;

  assign any_req = |req_valid;
  assign grant   = (req_valid == 2'b11) ? rr : req_valid[1];
  assign accept  = (state == IDLE) && any_req;
  assign sel_op  = grant ? req_op[5:3]  : req_op[2:0];
  assign sel_a   = grant ? req_a[63:32] : req_a[31:0];
  assign sel_b   = grant ? req_b[63:32] : req_b[31:0];

  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign rsp_valid = (state == RESP) ?
                     (port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

`ifdef ALU_DIVZERO_TRAP_EN
  logic err_q;

  assign trap = ((sel_op == 3'd3) || (sel_op == 3'd7)) &&
                (sel_b == 32'd0);
  assign rsp_err = err_q;
`else
  assign trap    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Decode remaining hold cycles for the granted opcode
  always_comb begin
    lat_m1 = '0;
    unique case (1'b1)
      (sel_op == 3'd2):
        lat_m1 = CW'(MUL_CYCLES - 1);
      (sel_op == 3'd3) || (sel_op == 3'd7):
        lat_m1 = CW'(DIV_CYCLES - 1);
      default:
        lat_m1 = '0;
    endcase
  end

  // Issue FSM: grant, hold operands, capture, hand back response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      port     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            port <= grant;
            rr   <= ~grant;
            if (trap) begin
              result_q <= '0;
              flags_q  <= 4'b0010;
              state    <= RESP;
            end else begin
              op_q  <= sel_op;
              a_q   <= sel_a;
              b_q   <= sel_b;
              cnt   <= lat_m1;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result_q <= alu_result;
            flags_q  <= {alu_v, alu_c, alu_z, alu_s};
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[port]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_DIVZERO_TRAP_EN
  // Trap flag follows whichever response was last produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && trap) begin
      err_q <= 1'b1;
    end else if ((state == EXEC) && (cnt == '0)) begin
      err_q <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single combinational 32-bit ALU between two requesters (port 0: execute stage, port 1: address/auxiliary unit) with round-robin arbitration. It latches one operation at a time, holds ALU operands stable for the op's multicycle latency, and captures result and flags. It returns them on a shared response bus with valid/ready handshaking. It sits between the issue logic and the ALU instance in the CPU datapath.

## Interface
- MUL_CYCLES, 2, cycles operands are held for op 2 (mul); must be ≥1
- DIV_CYCLES, 4, cycles operands are held for ops 3 (div) and 7 (mod); must be ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-port request valid, bit p = port p
- req_ready  out  2  per-port accept, combinational, one-hot or zero
- req_op  in  6  {op1, op0}, 3-bit ALU opcodes
- req_a, req_b  in  64  {a1, a0}, {b1, b0}, signed 32-bit operands
- rsp_valid  out  2  one-hot: response for port p pending
- rsp_ready  in  2  per-port response accept
- rsp_result  out  32  captured result
- rsp_flags  out  4  captured {V, C, Z, S}
- rsp_err  out  1  divide-by-zero trap (see Configuration)
- alu_a, alu_b  out  32  operands to ALU
- alu_op  out  3  ALU opcode
- alu_result  in  32  ALU result
- alu_v, alu_c, alu_z, alu_s  in  1  ALU flags

## Operation
- States: IDLE, EXEC, RESP. Reset: IDLE, rr=0, all outputs and internal registers 0.
- IDLE: if any req_valid, grant one port.
  - Only one valid: grant that port.
  - Both valid: grant port rr.
  - req_ready[grant]=1 this cycle; accepted on valid&ready.
  - Latch op, a, b and port id; set rr = ~grant.
  - Load cnt = latency-1 and go to EXEC.
- Latency: ops 0,1,4,5,6 = 1; op 2 = MUL_CYCLES; ops 3,7 = DIV_CYCLES.
- EXEC: alu_a/alu_b/alu_op driven from the latched registers.
  - cnt≠0: decrement.
  - cnt==0: capture alu_result and {alu_v,alu_c,alu_z,alu_s}; go to RESP.
- RESP: rsp_valid[port]=1.
  - Result, flags and err stay stable until rsp_ready[port]=1, then go to IDLE.
  - rsp_ready on the other port, or while rsp_valid=0, is ignored.
- req_ready=0 in EXEC and RESP. Only one operation is outstanding.
- alu_a/alu_b/alu_op hold their last latched values in IDLE and RESP.
- Flags and result pass through unmodified; widths stay 32 bits with no extension.

## Timing
- Request accepted at edge 0:
  - 1-cycle op: EXEC in cycle 1, rsp_valid from cycle 2.
  - op 2 (MUL_CYCLES=2): rsp_valid from cycle 3.
  - ops 3/7 (DIV_CYCLES=4): rsp_valid from cycle 5.
- Trapped divide-by-zero: IDLE→RESP directly, rsp_valid in cycle 1.
- rsp_ready high in the first RESP cycle: IDLE in the next cycle, where a new request can be accepted. Minimum issue interval is 3 cycles.
- Requests arriving during EXEC/RESP wait; the rr pointer decides once IDLE is reached.
- rst_n low at any time: immediately clears to reset state. The in-flight op is dropped with no response.

## Configuration
- ALU_DIVZERO_TRAP_EN defined:
  - Ops 3/7 with b==0 are not issued to the ALU.
  - Response gives rsp_result=0, rsp_flags=4'b0010 (Z), rsp_err=1.
- Not defined:
  - Such ops are issued normally with DIV_CYCLES latency and the ALU output is returned as-is.
  - rsp_err is tied to 0.

## Test plan
- Port 0 op 0, a=0x7FFFFFFF, b=1, rsp_ready=1 → rsp_valid=2'b01 in cycle 2, rsp_result=0x80000000, V=1, S=1, Z=0.
- Both ports valid after reset (port0 op 1, 5−5; port1 op 4, 0xF0&0x3C):
  - Port 0 granted first; result 0 with Z=1.
  - Port 1 granted next in IDLE; result 0x30.
  - Repeat with both valid: port 0 granted again, since rr alternates.
- Port 1 op 2, a=−3, b=7, MUL_CYCLES=2 → rsp_valid=2'b10 in cycle 3, result 0xFFFFFFEB, S=1. alu_a/alu_b stable during both EXEC cycles.
- Port 0 op 3, a=100, b=0:
  - With ALU_DIVZERO_TRAP_EN: rsp in cycle 1, result 0, flags 4'b0010, err=1, alu_op unchanged.
  - Without: rsp in cycle 5, err=0.
- Backpressure: op 7, 17%5, rsp_ready held 0 for 4 cycles → rsp_valid, result 2 and flags stay stable. Port 1 request stays unaccepted (req_ready=0) until the cycle after rsp_ready=1.
- Assert rst_n low during EXEC of a DIV → outputs 0 asynchronously, no rsp_valid afterward, rr=0.
